// File: rtl/orb_wr_arbiter.sv
// Write-port arbiter for the ping-pong orbit frame RAMs: one buffered word per
// packer, one round-robin grant per clock, writes steered away from the read bank.
module orb_wr_arbiter #(
    parameter int N_REQ  = 5,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 12,
    parameter int GUARD  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          iWE,
    input  logic [N_REQ*ADDR_W-1:0]   iAddr,
    input  logic [N_REQ*DATA_W-1:0]   iWord,
    input  logic                      iSW,
    input  logic                      iClrOvf,
    output logic [ADDR_W-1:0]         oWrAddr,
    output logic [DATA_W-1:0]         oWrData,
    output logic                      oWE1,
    output logic                      oWE2,
    output logic [N_REQ-1:0]          oPend,
    output logic [N_REQ-1:0]          oOvf,
    output logic                      oHold
);
    localparam int               PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int               CND_W      = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(N_REQ - 1);
    localparam logic [3:0]       GUARD_LOAD = 4'(GUARD - 1);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              hold_q, hold_d;
    logic              sw_meta_q, sw_meta_d, sw_s_q, sw_s_d, sw_prev_q, sw_prev_d;
    logic [N_REQ-1:0]  valid_q, valid_d, ovf_q, ovf_d;
    logic [ADDR_W-1:0] addr_q [N_REQ];
    logic [ADDR_W-1:0] addr_d [N_REQ];
    logic [DATA_W-1:0] data_q [N_REQ];
    logic [DATA_W-1:0] data_d [N_REQ];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              we1_q, we1_d, we2_q, we2_d;

    logic              sw_toggle_s, run_s, gnt_vld_s;
    logic [PTR_W-1:0]  gnt_idx_s;
    logic [N_REQ-1:0]  gnt_oh_s;
    logic [CND_W-1:0]  cand_s;

    // Two-flop synchronizer for the serializer's bank select, plus its history.
    always_comb begin
        sw_meta_d   = iSW;
        sw_s_d      = sw_meta_q;
        sw_prev_d   = sw_s_q;
        sw_toggle_s = sw_s_q ^ sw_prev_q;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // FSM next state: any bank toggle (re)starts the guard interval.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (sw_toggle_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = GUARD_LOAD;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q;
                end
            end
            ST_HOLD: begin
                if (sw_toggle_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = GUARD_LOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        case (state_q)
            ST_RUN:  run_s = 1'b1;
            ST_HOLD: run_s = 1'b0;
            default: run_s = 1'b0;
        endcase
        hold_d = (state_d == ST_HOLD);
    end

    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        cand_s    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = {1'b0, ptr_q} + CND_W'(k);
            if (cand_s >= CND_W'(N_REQ)) begin
                cand_s = cand_s - CND_W'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (run_s && !gnt_vld_s && valid_q[cand_s[PTR_W-1:0]]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = cand_s[PTR_W-1:0];
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            gnt_oh_s[i] = gnt_vld_s && (gnt_idx_s == PTR_W'(i));
        end
        if (!gnt_vld_s) begin
            ptr_d = ptr_q;
        end else if (gnt_idx_s == LAST_IDX) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx_s + PTR_W'(1);
        end
    end

    // Slot capture and overflow: a full slot not drained this cycle keeps its old word.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (iClrOvf) begin
            ovf_d = '0;
        end else begin
            ovf_d = ovf_q;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (iWE[i] && valid_q[i] && !gnt_oh_s[i]) begin
                ovf_d[i] = 1'b1;
            end else if (iWE[i]) begin
                valid_d[i] = 1'b1;
                addr_d[i]  = iAddr[i*ADDR_W +: ADDR_W];
                data_d[i]  = iWord[i*DATA_W +: DATA_W];
            end else if (gnt_oh_s[i]) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
    end

    // Write port: bank chosen by the synchronized select in the grant cycle.
    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        we1_d     = 1'b0;
        we2_d     = 1'b0;
        if (gnt_vld_s) begin
            wr_addr_d = addr_q[gnt_idx_s];
            wr_data_d = data_q[gnt_idx_s];
            we1_d     = sw_s_q;
            we2_d     = !sw_s_q;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // Datapath, synchronizer and arbiter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q <= 1'b0;
            sw_s_q    <= 1'b0;
            sw_prev_q <= 1'b0;
            valid_q   <= '0;
            ovf_q     <= '0;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            we1_q     <= 1'b0;
            we2_q     <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_s_q    <= sw_s_d;
            sw_prev_q <= sw_prev_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            we1_q     <= we1_d;
            we2_q     <= we2_d;
            for (int i = 0; i < N_REQ; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign oWrAddr = wr_addr_q;
    assign oWrData = wr_data_q;
    assign oWE1    = we1_q;
    assign oWE2    = we2_q;
    assign oPend   = valid_q;
    assign oOvf    = ovf_q;
    assign oHold   = hold_q;

endmodule

// File: doc/orb_wr_arbiter.md
# orb_wr_arbiter

Write-port arbiter and bank scheduler for the ping-pong orbit frame RAMs. It collects write requests from up to N packers (fast 1/2, slow 1/2, temperature), each holding one buffered word, and grants one write per clock round-robin. It steers each write to the RAM bank not currently being read by the orbit serializer. It replaces the unprotected last-writer-wins priority mux, so simultaneous packer strobes no longer drop words silently.

## Interface
- N_REQ, 5, number of requesters (slot 0 = fast1, 1 = fast2, 2 = slow1, 3 = slow2, 4 = temp)
- ADDR_W, 11, RAM word address width
- DATA_W, 12, orbit word width
- GUARD, 4, idle cycles inserted after a bank switch (1..15)

Ports:
- clk  in  1  system clock (80 MHz domain); one clock
- rst  in  1  reset, synchronous, active-high
- iWE  in  N_REQ  per-requester single-cycle write strobe
- iAddr  in  N_REQ*ADDR_W  packed addresses; slot i at [i*ADDR_W +: ADDR_W]
- iWord  in  N_REQ*DATA_W  packed data; slot i at [i*DATA_W +: DATA_W]
- iSW  in  1  bank select from the serializer clock domain; asynchronous level
- iClrOvf  in  1  clears oOvf
- oWrAddr  out  ADDR_W  registered write address
- oWrData  out  DATA_W  registered write data
- oWE1  out  1  write strobe, bank 1
- oWE2  out  1  write strobe, bank 2
- oPend  out  N_REQ  slot-valid flags
- oOvf  out  N_REQ  sticky overflow flags
- oHold  out  1  high while in HOLD state

## Operation
- iSW passes through a 2-flop synchronizer to give swS. Target bank is swS=0 → bank 2 (oWE2), swS=1 → bank 1 (oWE1).
- Each slot i is a 1-deep buffer {valid, addr, data}. When iWE[i] is high, the slot captures iAddr/iWord slice i and sets valid.
- Capture while valid with no grant to i in the same cycle:
  - the new word is dropped;
  - the buffered word is kept;
  - oOvf[i] is set.
- Grant to i and a new iWE[i] in the same cycle: the old word is written, the new word is captured, and no overflow occurs.
- Round-robin pointer ptr (0..N_REQ-1):
  - search order is ptr, ptr+1, …, wrapping modulo N_REQ;
  - the first valid slot wins;
  - after a grant to i, ptr becomes (i+1) mod N_REQ;
  - with no grant, ptr is unchanged.
- FSM with two states:
  - RUN: grants one valid slot per cycle.
  - HOLD: no grants. Slots still capture, and overflow rules still apply.
  - RUN → HOLD when swS differs from its previous-cycle value (either edge). A GUARD counter loads GUARD-1.
  - HOLD → RUN when the counter reaches 0, counting down each cycle.
  - A swS toggle during HOLD reloads the counter.
- Granted write:
  - oWrAddr/oWrData take the slot contents;
  - the strobe of the target bank is decided by swS in the grant cycle;
  - the slot's valid bit clears.
- oWE1 and oWE2 are never high together. Both are 0 in HOLD and when no slot is valid.
- oWrAddr/oWrData hold their last values when no write occurs.
- iClrOvf clears every oOvf bit. If iClrOvf coincides with a new overflow on slot i, oOvf[i] ends at 1 (set wins).
- Reset values:
  - all slots invalid; ptr = 0; state RUN;
  - swS and its history = 0;
  - oWrAddr = 0, oWrData = 0;
  - oWE1 = 0, oWE2 = 0;
  - oPend = 0, oOvf = 0, oHold = 0.
- Reset mid-operation: buffered words are discarded with no write. Reset overrides iClrOvf and iWE.

## Timing
- iWE[i] sampled at edge k → oPend[i] high after k.
- Earliest write: oWE high after edge k+1, so capture-to-strobe latency is 1 cycle with an idle arbiter.
- Worst case in RUN with all N_REQ slots contending: a slot is written within N_REQ cycles of capture.
- oWE* is a single-cycle pulse per granted word. Back-to-back grants give continuous strobes with changing addresses.
- iSW change → swS after 2 edges → HOLD begins the next cycle (oHold=1) → lasts exactly GUARD cycles with no strobes.
- oPend[i] falls on the same edge its oWE pulse rises.
- Downstream RAM captures oWrAddr/oWrData/oWE* on the edge after they are driven; no further handshake exists.

## Test plan
- Single request:
  - stimulus: iWE=5'b00001, iAddr slot0=11'd100, iWord=12'hABC, iSW=0;
  - response: one cycle later, oWE2=1 for 1 cycle with oWrAddr=100, oWrData=ABC; oWE1=0; oPend returns to 0.
- All-slot collision:
  - stimulus: iWE=5'b11111 in one cycle, addresses 10..14, ptr=0;
  - response: five consecutive oWE2 pulses at addresses 10,11,12,13,14; oOvf=0.
- Round-robin fairness:
  - stimulus: slots 0 and 3 re-requested every time they are written;
  - response: grants alternate 0,3,0,3; neither is starved.
- Overflow:
  - stimulus: slot 2 gets iWE with word 12'h111; next cycle, iWE slot 2 with 12'h222 while slot 0 holds the grant;
  - response: 12'h111 is written, 12'h222 is lost, oOvf[2]=1 until iClrOvf is pulsed.
- Bank switch:
  - stimulus: iSW 0→1 with slot 4 pending;
  - response: oHold=1 for exactly 4 cycles with no strobes; the pending word is then written with oWE1=1, oWE2=0.
- Reset mid-operation:
  - stimulus: assert rst for 1 cycle while 3 slots are pending;
  - response: no strobes follow; oPend=0, oOvf=0, ptr=0; a subsequent slot-1 request is written first.
